// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a framed image, assembles MSB-first words,
// writes them to instruction memory and releases the core once the checksum matches.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_restart,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_im_we,
    output logic [31:0]       o_im_addr,
    output logic [31:0]       o_im_wd,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [ADDR_W:0]   o_words_loaded
);

    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
    localparam int unsigned LEN_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_rx_ready;
    logic                r_im_we;
    logic [31:0]         r_im_addr;
    logic [31:0]         r_im_wd;
    logic                r_cpu_hold;
    logic                r_load_done;
    logic                r_load_err;
    logic [ADDR_W:0]     r_words_loaded;

    logic [7:0]          r_len_hi;
    logic [LEN_W-1:0]    r_len;
    logic [7:0]          r_csum;
    logic [23:0]         r_sh;
    logic [1:0]          r_byte_idx;
    logic [ADDR_W-1:0]   r_word_idx;

    logic                w_xfer;
    logic [LEN_W-1:0]    w_len_full;
    logic                w_word_done;
    logic                w_last_word;
    logic                w_rx_ready_d;
    logic                w_cpu_hold_d;
    logic                w_load_done_d;
    logic                w_load_err_d;

    assign w_xfer      = i_rx_valid & r_rx_ready;
    assign w_len_full  = {r_len_hi, i_rx_data};
    assign w_word_done = w_xfer && (r_state == S_DATA) && (r_byte_idx == 2'd3);
    assign w_last_word = (LEN_W'(r_word_idx) + LEN_W'(1)) == r_len;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; restart overrides any same-cycle transfer
    always_comb begin
        w_state_next = r_state;
        if (i_restart) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:   if (w_xfer && i_rx_data == SYNC_BYTE) w_state_next = S_LEN_HI;
                S_LEN_HI: if (w_xfer) w_state_next = S_LEN_LO;
                S_LEN_LO: if (w_xfer) begin
                    if (w_len_full > LEN_W'(MAX_WORDS)) w_state_next = S_ERR;
                    else if (w_len_full == '0)          w_state_next = S_CSUM;
                    else                                w_state_next = S_DATA;
                end
                S_DATA:   if (w_word_done && w_last_word) w_state_next = S_CSUM;
                S_CSUM:   if (w_xfer) w_state_next = (i_rx_data == r_csum) ? S_DONE : S_ERR;
                S_DONE:   w_state_next = S_DONE;
                S_ERR:    w_state_next = S_ERR;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the upcoming state, then registered
    always_comb begin
        w_rx_ready_d  = 1'b0;
        w_cpu_hold_d  = 1'b1;
        w_load_done_d = 1'b0;
        w_load_err_d  = 1'b0;
        if (!i_restart) begin
            unique case (w_state_next)
                S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: w_rx_ready_d = 1'b1;
                S_DONE: begin
                    w_cpu_hold_d  = 1'b0;
                    w_load_done_d = 1'b1;
                end
                S_ERR:   w_load_err_d = 1'b1;
                default: w_rx_ready_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_ready  <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_rx_ready  <= w_rx_ready_d;
            r_cpu_hold  <= w_cpu_hold_d;
            r_load_done <= w_load_done_d;
            r_load_err  <= w_load_err_d;
        end
    end

    // Frame datapath: length, checksum, word assembly and memory write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im_we        <= 1'b0;
            r_im_addr      <= '0;
            r_im_wd        <= '0;
            r_words_loaded <= '0;
            r_len_hi       <= '0;
            r_len          <= '0;
            r_csum         <= '0;
            r_sh           <= '0;
            r_byte_idx     <= '0;
            r_word_idx     <= '0;
        end else if (i_restart) begin
            r_im_we        <= 1'b0;
            r_im_addr      <= '0;
            r_im_wd        <= '0;
            r_words_loaded <= '0;
            r_byte_idx     <= '0;
            r_word_idx     <= '0;
        end else begin
            r_im_we <= 1'b0;
            if (w_xfer) begin
                unique case (r_state)
                    S_IDLE: if (i_rx_data == SYNC_BYTE) begin
                        r_csum         <= '0;
                        r_words_loaded <= '0;
                    end
                    S_LEN_HI: begin
                        r_len_hi <= i_rx_data;
                        r_csum   <= r_csum ^ i_rx_data;
                    end
                    S_LEN_LO: begin
                        r_len      <= w_len_full;
                        r_csum     <= r_csum ^ i_rx_data;
                        r_byte_idx <= '0;
                        r_word_idx <= '0;
                    end
                    S_DATA: begin
                        r_sh       <= {r_sh[15:0], i_rx_data};
                        r_csum     <= r_csum ^ i_rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_im_we        <= 1'b1;
                            r_im_wd        <= {r_sh, i_rx_data};
                            r_im_addr      <= 32'({r_word_idx, 2'b00});
                            r_word_idx     <= r_word_idx + ADDR_W'(1);
                            r_words_loaded <= r_words_loaded + (ADDR_W+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rx_ready     = r_rx_ready;
    assign o_im_we        = r_im_we;
    assign o_im_addr      = r_im_addr;
    assign o_im_wd        = r_im_wd;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_load_done    = r_load_done;
    assign o_load_err     = r_load_err;
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes,
// an independent monitor pops and compares them on every im_we pulse.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_restart;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic              o_im_we;
    logic [31:0]       o_im_addr;
    logic [31:0]       o_im_wd;
    logic              o_cpu_hold;
    logic              o_load_done;
    logic              o_load_err;
    logic [ADDR_W:0]   o_words_loaded;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  frm[$];

    imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_restart      (i_restart),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_rx_ready     (o_rx_ready),
        .o_im_we        (o_im_we),
        .o_im_addr      (o_im_addr),
        .o_im_wd        (o_im_wd),
        .o_cpu_hold     (o_cpu_hold),
        .o_load_done    (o_load_done),
        .o_load_err     (o_load_err),
        .o_words_loaded (o_words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: every im_we pulse must match the head of the expected queue
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (o_im_we) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write addr=%h data=%h", o_im_addr, o_im_wd);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_im_addr, o_im_wd} !== e) begin
                        bad++;
                        $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                                 o_im_addr, o_im_wd, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_vals(input string tag);
        chk({tag, "_ready"}, 64'(o_rx_ready), 64'd0);
        chk({tag, "_we"},    64'(o_im_we), 64'd0);
        chk({tag, "_addr"},  64'(o_im_addr), 64'd0);
        chk({tag, "_wd"},    64'(o_im_wd), 64'd0);
        chk({tag, "_hold"},  64'(o_cpu_hold), 64'd1);
        chk({tag, "_done"},  64'(o_load_done), 64'd0);
        chk({tag, "_err"},   64'(o_load_err), 64'd0);
        chk({tag, "_words"}, 64'(o_words_loaded), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_rx_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout byte=%h", b);
            i_rx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (gap > 0) begin
            i_rx_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_frm(input int gap);
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i], gap);
        i_rx_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        i_restart = 1'b1;
        @(posedge clk); #1;
        i_restart = 1'b0;
    endtask

    task automatic load_good2();
        frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h28};
    endtask

    task automatic push_good2();
        exp_q.push_back({32'h0000_0000, 32'h1234_5678});
        exp_q.push_back({32'h0000_0004, 32'hDEAD_BEEF});
    endtask

    initial begin
        logic [7:0] cs;
        logic [7:0] b0, b1, b2, b3;
        reset      = 1'b0;
        i_restart  = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        #12;
        chk_idle_vals("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Good two-word frame preceded by noise bytes
        load_good2();
        frm.push_front(8'hFF);
        frm.push_front(8'h00);
        push_good2();
        send_frm(0);
        chk("good_done",  64'(o_load_done), 64'd1);
        chk("good_hold",  64'(o_cpu_hold), 64'd0);
        chk("good_err",   64'(o_load_err), 64'd0);
        chk("good_words", 64'(o_words_loaded), 64'd2);
        chk("good_ready", 64'(o_rx_ready), 64'd0);
        chk("good_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("done_sticky", 64'(o_load_done), 64'd1);

        // Restart from DONE
        pulse_restart();
        chk_idle_vals("restart_done");
        @(posedge clk); #1;
        chk("restart_idle_ready", 64'(o_rx_ready), 64'd1);

        // Bad checksum
        load_good2();
        frm[frm.size()-1] = 8'h29;
        push_good2();
        send_frm(0);
        chk("bad_err",   64'(o_load_err), 64'd1);
        chk("bad_hold",  64'(o_cpu_hold), 64'd1);
        chk("bad_done",  64'(o_load_done), 64'd0);
        chk("bad_ready", 64'(o_rx_ready), 64'd0);
        chk("bad_words", 64'(o_words_loaded), 64'd2);
        chk("bad_pending", 64'(exp_q.size()), 64'd0);
        pulse_restart();

        // Oversize length rejected straight after LEN_LO
        frm = '{8'hA5, 8'h01, 8'h01};
        send_frm(0);
        chk("big_err",   64'(o_load_err), 64'd1);
        chk("big_ready", 64'(o_rx_ready), 64'd0);
        chk("big_words", 64'(o_words_loaded), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        pulse_restart();

        // Zero-length frame
        frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frm(0);
        chk("zero_done",  64'(o_load_done), 64'd1);
        chk("zero_hold",  64'(o_cpu_hold), 64'd0);
        chk("zero_words", 64'(o_words_loaded), 64'd0);
        pulse_restart();

        // rx_valid toggling every cycle
        load_good2();
        push_good2();
        send_frm(1);
        chk("tog_done",  64'(o_load_done), 64'd1);
        chk("tog_words", 64'(o_words_loaded), 64'd2);
        chk("tog_pending", 64'(exp_q.size()), 64'd0);
        pulse_restart();

        // Asynchronous reset after the second data byte, then a fresh load
        frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        send_frm(0);
        reset = 1'b0;
        #1;
        chk_idle_vals("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        load_good2();
        push_good2();
        send_frm(0);
        chk("reload_done",  64'(o_load_done), 64'd1);
        chk("reload_words", 64'(o_words_loaded), 64'd2);
        chk("reload_pending", 64'(exp_q.size()), 64'd0);
        pulse_restart();

        // Restart coincident with the fourth data byte: byte dropped, no write
        frm = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
        send_frm(0);
        i_rx_data  = 8'h44;
        i_rx_valid = 1'b1;
        i_restart  = 1'b1;
        @(posedge clk); #1;
        i_restart  = 1'b0;
        i_rx_valid = 1'b0;
        chk("rsx_we",    64'(o_im_we), 64'd0);
        chk("rsx_ready", 64'(o_rx_ready), 64'd0);
        chk("rsx_hold",  64'(o_cpu_hold), 64'd1);
        chk("rsx_words", 64'(o_words_loaded), 64'd0);
        @(posedge clk); #1;
        chk("rsx_idle_ready", 64'(o_rx_ready), 64'd1);

        // Full-capacity frame: 256 words, rx_valid held high
        frm = '{8'hA5, 8'h01, 8'h00};
        cs = 8'h01;
        for (int i = 0; i < 256; i++) begin
            b0 = 8'(i);
            b1 = 8'(i) ^ 8'h5A;
            b2 = ~8'(i);
            b3 = 8'h3C;
            frm.push_back(b0); frm.push_back(b1); frm.push_back(b2); frm.push_back(b3);
            cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
            exp_q.push_back({32'(i * 4), b0, b1, b2, b3});
        end
        frm.push_back(cs);
        send_frm(0);
        chk("max_done",  64'(o_load_done), 64'd1);
        chk("max_words", 64'(o_words_loaded), 64'd256);
        chk("max_last_addr", 64'(o_im_addr), 64'h3FC);
        chk("max_pending", 64'(exp_q.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
